// File: rtl/avaliador_jogada.sv
// rtl/avaliador_jogada.sv - note/timing judge for the piano game, one evaluation per iniciar.
// Optional chord capture window is compiled in with `define ACORDE_EN.
module avaliador_jogada #(
    parameter int NUM_KEYS      = 13,
    parameter int DUR_W         = 8,
    parameter int TOL_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 32,
    parameter int MAX_ERROS     = 3,
    parameter int CHORD_WIN     = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             iniciar,
    input  logic [NUM_KEYS-1:0]              nota_esperada,
    input  logic [DUR_W-1:0]                 duracao_esp,
    input  logic                             tick,
    input  logic [NUM_KEYS-1:0]              botoes,
    input  logic                             zera_erros,
    output logic                             pronto,
    output logic                             nota_correta,
    output logic                             tempo_correto,
    output logic                             tempo_baixo,
    output logic                             tempo_alto,
    output logic                             timeout,
    output logic [$clog2(MAX_ERROS+1)-1:0]   erros,
    output logic                             perdeu,
    output logic [2:0]                       db_estado
);

    localparam int ERR_W  = $clog2(MAX_ERROS + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DUR_W-1:0]        HOLD_MAX = {DUR_W{1'b1}};
    localparam logic signed [DUR_W:0]   TOL_S    = (DUR_W + 1)'(TOL_TICKS);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ESPERA    = 3'd1,
        SEGURA    = 3'd2,
        AVALIA    = 3'd3,
        RESULTADO = 3'd4
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [WAIT_W-1:0]   espera_cnt_q, espera_cnt_d;
    logic [DUR_W-1:0]    hold_q, hold_d;
    logic [NUM_KEYS-1:0] mask_tocada_q, mask_tocada_d;
    logic                nota_errada_q, nota_errada_d;
    logic                pronto_q, pronto_d;
    logic                nota_correta_q, nota_correta_d;
    logic                tempo_correto_q, tempo_correto_d;
    logic                tempo_baixo_q, tempo_baixo_d;
    logic                tempo_alto_q, tempo_alto_d;
    logic                timeout_q, timeout_d;
    logic [ERR_W-1:0]    erros_q, erros_d;
    logic                perdeu_q, perdeu_d;
`ifdef ACORDE_EN
    localparam int CW_W = $clog2(CHORD_WIN + 1) < 1 ? 1 : $clog2(CHORD_WIN + 1);
    logic [CW_W-1:0]     acorde_cnt_q, acorde_cnt_d;
`endif

    logic signed [DUR_W:0] diff;
    logic [NUM_KEYS-1:0]   novas;
    logic                  errada_final;
    logic                  baixo_c, alto_c;
    logic                  falha;

    always_comb begin
        // Hold minus expected: one extra bit keeps both signs representable.
        diff    = $signed({1'b0, hold_q}) - $signed({1'b0, duracao_esp});
        baixo_c = diff < -TOL_S;
        alto_c  = diff > TOL_S;
        novas   = botoes & ~mask_tocada_q;
        falha   = !nota_correta_q || !tempo_correto_q;
`ifdef ACORDE_EN
        errada_final = nota_errada_q;
`else
        errada_final = nota_errada_q ||
                       (|(mask_tocada_q & (mask_tocada_q - NUM_KEYS'(1))));
`endif

        estado_d        = estado_q;
        espera_cnt_d    = espera_cnt_q;
        hold_d          = hold_q;
        mask_tocada_d   = mask_tocada_q;
        nota_errada_d   = nota_errada_q;
        pronto_d        = 1'b0;
        nota_correta_d  = nota_correta_q;
        tempo_correto_d = tempo_correto_q;
        tempo_baixo_d   = tempo_baixo_q;
        tempo_alto_d    = tempo_alto_q;
        timeout_d       = timeout_q;
        erros_d         = erros_q;
        perdeu_d        = perdeu_q;
`ifdef ACORDE_EN
        acorde_cnt_d    = acorde_cnt_q;
`endif

        case (estado_q)
            OCIOSO: begin
                if (iniciar && !perdeu_q) begin
                    estado_d        = ESPERA;
                    espera_cnt_d    = '0;
                    hold_d          = '0;
                    mask_tocada_d   = '0;
                    nota_errada_d   = 1'b0;
                    nota_correta_d  = 1'b0;
                    tempo_correto_d = 1'b0;
                    tempo_baixo_d   = 1'b0;
                    tempo_alto_d    = 1'b0;
                    timeout_d       = 1'b0;
`ifdef ACORDE_EN
                    acorde_cnt_d    = '0;
`endif
                end
            end
            ESPERA: begin
                if (botoes != '0) begin
                    estado_d      = SEGURA;
                    mask_tocada_d = botoes;
                    hold_d        = '0;
                end else if (tick) begin
                    if (espera_cnt_q == WAIT_W'(TIMEOUT_TICKS - 1)) begin
                        estado_d  = AVALIA;
                        timeout_d = 1'b1;
                    end else begin
                        espera_cnt_d = espera_cnt_q + WAIT_W'(1);
                    end
                end
            end
            SEGURA: begin
                // The release cycle still counts its tick.
                if (tick && hold_q != HOLD_MAX)
                    hold_d = hold_q + DUR_W'(1);
`ifdef ACORDE_EN
                if (acorde_cnt_q < CW_W'(CHORD_WIN)) begin
                    mask_tocada_d = mask_tocada_q | botoes;
                    if (tick)
                        acorde_cnt_d = acorde_cnt_q + CW_W'(1);
                end else if (novas != '0) begin
                    nota_errada_d = 1'b1;
                end
`else
                if (novas != '0)
                    nota_errada_d = 1'b1;
`endif
                if (botoes == '0)
                    estado_d = AVALIA;
            end
            AVALIA: begin
                estado_d = RESULTADO;
                pronto_d = 1'b1;
                if (timeout_q) begin
                    nota_correta_d  = 1'b0;
                    tempo_correto_d = 1'b0;
                    tempo_baixo_d   = 1'b0;
                    tempo_alto_d    = 1'b0;
                end else begin
                    nota_correta_d  = !errada_final && (mask_tocada_q == nota_esperada);
                    tempo_baixo_d   = baixo_c;
                    tempo_alto_d    = alto_c;
                    tempo_correto_d = !baixo_c && !alto_c;
                end
            end
            RESULTADO: begin
                estado_d = OCIOSO;
                if (falha) begin
                    if (erros_q != ERR_W'(MAX_ERROS))
                        erros_d = erros_q + ERR_W'(1);
                    perdeu_d = (erros_d == ERR_W'(MAX_ERROS));
                end
            end
            default: estado_d = OCIOSO;
        endcase

        if (zera_erros) begin
            erros_d  = '0;
            perdeu_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q        <= OCIOSO;
            espera_cnt_q    <= '0;
            hold_q          <= '0;
            mask_tocada_q   <= '0;
            nota_errada_q   <= 1'b0;
            pronto_q        <= 1'b0;
            nota_correta_q  <= 1'b0;
            tempo_correto_q <= 1'b0;
            tempo_baixo_q   <= 1'b0;
            tempo_alto_q    <= 1'b0;
            timeout_q       <= 1'b0;
            erros_q         <= '0;
            perdeu_q        <= 1'b0;
`ifdef ACORDE_EN
            acorde_cnt_q    <= '0;
`endif
        end else begin
            estado_q        <= estado_d;
            espera_cnt_q    <= espera_cnt_d;
            hold_q          <= hold_d;
            mask_tocada_q   <= mask_tocada_d;
            nota_errada_q   <= nota_errada_d;
            pronto_q        <= pronto_d;
            nota_correta_q  <= nota_correta_d;
            tempo_correto_q <= tempo_correto_d;
            tempo_baixo_q   <= tempo_baixo_d;
            tempo_alto_q    <= tempo_alto_d;
            timeout_q       <= timeout_d;
            erros_q         <= erros_d;
            perdeu_q        <= perdeu_d;
`ifdef ACORDE_EN
            acorde_cnt_q    <= acorde_cnt_d;
`endif
        end
    end

    assign pronto        = pronto_q;
    assign nota_correta  = nota_correta_q;
    assign tempo_correto = tempo_correto_q;
    assign tempo_baixo   = tempo_baixo_q;
    assign tempo_alto    = tempo_alto_q;
    assign timeout       = timeout_q;
    assign erros         = erros_q;
    assign perdeu        = perdeu_q;
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_avaliador_jogada.sv
// tb/tb_avaliador_jogada.sv - randomized bench for avaliador_jogada against a grading model.
module tb_avaliador_jogada;

    localparam int MAXE = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [12:0] nota_esperada;
    logic [7:0]  duracao_esp;
    logic        tick;
    logic [12:0] botoes;
    logic        zera_erros;
    logic        pronto, nota_correta, tempo_correto, tempo_baixo, tempo_alto, timeout;
    logic [1:0]  erros;
    logic        perdeu;
    logic [2:0]  db_estado;

    int vectors     = 0;
    int miscompares = 0;
    int errs_m      = 0;

    avaliador_jogada dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .nota_esperada(nota_esperada),
        .duracao_esp(duracao_esp), .tick(tick), .botoes(botoes), .zera_erros(zera_erros),
        .pronto(pronto), .nota_correta(nota_correta), .tempo_correto(tempo_correto),
        .tempo_baixo(tempo_baixo), .tempo_alto(tempo_alto), .timeout(timeout),
        .erros(erros), .perdeu(perdeu), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick_gap();
        repeat ($urandom_range(0, 2)) @(negedge clock);
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
    endtask

    // Lost game: iniciar must be ignored until the error count is cleared.
    task automatic recupera();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("ignora_iniciar", int'(db_estado), 0);
        @(negedge clock);
        check("ignora_pronto", int'(pronto), 0);
        zera_erros = 1'b1;
        @(negedge clock);
        zera_erros = 1'b0;
        check("zera_erros", int'(erros), 0);
        check("zera_perdeu", int'(perdeu), 0);
        errs_m = 0;
    endtask

    task automatic run_eval(input logic [12:0] esp, input int dur, input bit press,
                            input int wait_t, input logic [12:0] first, input logic [12:0] extra,
                            input int extra_k, input int hold_t, input bit rel_tick,
                            input bit zera);
        logic [12:0] played;
        bit errada, nc, tc, tb, ta, to;
        int h, d, lat;
        if (errs_m == MAXE) recupera();
        nota_esperada = esp;
        duracao_esp   = dur[7:0];
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("estado_espera", int'(db_estado), 1);
        check("flags_limpas", int'({nota_correta, tempo_correto, tempo_baixo, tempo_alto, timeout}), 0);
        if (!press) begin
            for (int i = 0; i < 32; i++) tick_gap();
        end else begin
            for (int i = 0; i < wait_t; i++) tick_gap();
            botoes = first;
            @(negedge clock);
            for (int k = 0; k < hold_t; k++) begin
                if (k == extra_k) begin
                    botoes = botoes | extra;
                    @(negedge clock);
                end
                tick_gap();
            end
            botoes = '0;
            tick   = rel_tick;
            @(negedge clock);
            tick = 1'b0;
        end

        to     = !press;
        played = first;
        errada = 1'b0;
        if (press && extra_k < hold_t) begin
`ifdef ACORDE_EN
            if (extra_k < 2) played = played | extra;
            else errada = (extra & ~first) != 0;
`else
            errada = (extra & ~first) != 0;
`endif
        end
`ifndef ACORDE_EN
        if ($countones(played) > 1) errada = 1'b1;
`endif
        nc = !to && !errada && (played == esp);
        h  = hold_t + int'(rel_tick);
        if (h > 255) h = 255;
        d  = h - dur;
        tc = !to && d >= -2 && d <= 2;
        tb = !to && d < -2;
        ta = !to && d > 2;
        if (!nc || !tc) errs_m = (errs_m < MAXE) ? errs_m + 1 : MAXE;
        if (zera) errs_m = 0;

        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (pronto) begin
                lat = i;
                break;
            end
        end
        check("latencia", lat, 1);
        check("nota_correta", int'(nota_correta), int'(nc));
        check("tempo_correto", int'(tempo_correto), int'(tc));
        check("tempo_baixo", int'(tempo_baixo), int'(tb));
        check("tempo_alto", int'(tempo_alto), int'(ta));
        check("timeout", int'(timeout), int'(to));
        zera_erros = zera;
        @(negedge clock);
        zera_erros = 1'b0;
        check("pronto_pulso", int'(pronto), 0);
        check("erros", int'(erros), errs_m);
        check("perdeu", int'(perdeu), int'(errs_m == MAXE));
        check("volta_ocioso", int'(db_estado), 0);
        check("flags_mantidas", int'(nota_correta), int'(nc));
    endtask

    initial begin
        logic [12:0] esp, first, extra;
        int dur, hold, r, seen;
        reset = 1'b1; iniciar = 1'b0; tick = 1'b0; botoes = '0; zera_erros = 1'b0;
        nota_esperada = '0; duracao_esp = '0;
        @(negedge clock);
        check("reset_saidas", int'({pronto, nota_correta, tempo_correto, tempo_baixo,
                                    tempo_alto, timeout, erros, perdeu, db_estado}), 0);
        reset = 1'b0;
        @(negedge clock);

        run_eval(13'h0010, 8, 1, 3, 13'h0010, '0, 99, 8, 0, 0);
        run_eval(13'h0010, 8, 1, 3, 13'h0010, '0, 99, 5, 0, 0);
        run_eval(13'h0010, 8, 1, 3, 13'h0010, '0, 99, 11, 0, 0);
        run_eval(13'h0010, 8, 1, 0, 13'h0010, '0, 99, 2, 0, 1);
        for (int i = 0; i < 3; i++) run_eval(13'h0010, 8, 0, 0, '0, '0, 99, 0, 0, 0);
        run_eval(13'h0010, 8, 1, 2, 13'h0010, 13'h0080, 3, 8, 0, 0);
        run_eval(13'h0091, 6, 1, 1, 13'h0001, 13'h0090, 1, 6, 0, 0);

        // Reset during SEGURA: abort, everything back to zero, no pronto.
        nota_esperada = 13'h0010; duracao_esp = 8'd8;
        iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
        botoes = 13'h0010; @(negedge clock);
        tick_gap(); tick_gap();
        reset = 1'b1;
        #1;
        check("reset_segura", int'({pronto, nota_correta, tempo_correto, tempo_baixo,
                                    tempo_alto, timeout, erros, perdeu, db_estado}), 0);
        @(negedge clock);
        botoes = '0; reset = 1'b0; errs_m = 0;
        seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (pronto) seen++;
        end
        check("reset_sem_pronto", seen, 0);

        run_eval(13'h0004, 1, 1, 0, 13'h0004, '0, 99, 0, 0, 0);
        run_eval(13'h0004, 10, 1, 0, 13'h0004, '0, 99, 12, 0, 0);
        run_eval(13'h0004, 10, 1, 0, 13'h0004, '0, 99, 8, 0, 0);
        run_eval(13'h0004, 255, 1, 0, 13'h0004, '0, 99, 258, 0, 0);
        run_eval(13'h0004, 10, 1, 0, 13'h0004, '0, 99, 13, 0, 0);
        run_eval(13'h0004, 10, 1, 0, 13'h0004, '0, 99, 7, 0, 0);
        run_eval(13'h0004, 10, 1, 0, 13'h0004, '0, 99, 12, 1, 0);

        for (int n = 0; n < 120; n++) begin
            esp = 13'(1) << $urandom_range(0, 12);
            if ($urandom_range(0, 5) == 0) esp = 13'($urandom_range(1, 8191));
            first = ($urandom_range(0, 3) != 0) ? esp : 13'(1) << $urandom_range(0, 12);
            extra = ($urandom_range(0, 3) == 0) ? 13'(1) << $urandom_range(0, 12) : 13'(0);
            dur  = $urandom_range(0, 16);
            r    = $urandom_range(0, 8);
            hold = dur + r - 4;
            if (hold < 0) hold = 0;
            run_eval(esp, dur, $urandom_range(0, 9) != 0, $urandom_range(0, 6), first, extra,
                     $urandom_range(0, hold), hold, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
